tdc_readout_packer: RTL
=======================

// Module: tdc_readout_packer
// PURPOSE
//  Downstream of the multi-TDC FIFO mux. Pops 40-bit hit words from the merged first-word-fall-through (FWFT) view.
//  Frames them into packets: HEADER, DATA..., TRAILER. Presents packets on a valid/ready stream to the readout link FIFO.
//  Packet close conditions: word limit, matching done, or idle timeout.
// PARAMETERS
//  TDC_DATA_WIDTH  40    width of hit word and of every output word (>=36)
//  MAX_WORDS       256   max DATA words per packet (1..2**CNT_WIDTH-1)
//  TIMEOUT         1024  consecutive empty cycles in DATA before forced close (>=1)
//  CNT_WIDTH       12    width of word counter in trailer
// PORTS
//  clk                 in   1    system clock
//  rst_n               in   1    synchronous reset, active low
//  tdc_fifo_empty_mux  in   1    merged FIFO empty
//  tdc_fifo_data_mux   in   TDC_DATA_WIDTH  FWFT head word, valid when !empty
//  matching_busy_mux   in   1    some locked TDC still matching
//  tdc_fifo_read_mux   out  1    pop strobe; data consumed same cycle
//  out_data            out  TDC_DATA_WIDTH  packet word
//  out_valid           out  1    out_data valid
//  out_sof             out  1    word is HEADER (qualified by out_valid)
//  out_eof             out  1    word is TRAILER (qualified by out_valid)
//  out_ready           in   1    consumer accepts when out_valid&out_ready
//  pkt_count           out  16   packets completed since reset (wraps)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; out_valid/out_sof/out_eof/out_data/pkt_count all 0.
//   Counters cleared. tdc_fifo_read_mux=0 combinationally while rst_n=0.
//   Mid-packet reset drops the partial packet; no trailer emitted.
//  Output stage: single register. It loads when load_ok = !out_valid | out_ready.
//   out_valid is held with data stable until accepted.
//  FSM:
//   IDLE:    if !empty -> HEADER.
//   HEADER:  on load_ok, load {4'hA, pkt_id[15:0], 0...}, sof=1 -> DATA. Clear word_cnt and idle_cnt.
//   DATA:    pop = !empty & load_ok & (word_cnt<MAX_WORDS). A pop loads head word unchanged, word_cnt++, idle_cnt=0.
//            If empty, idle_cnt++ (saturating).
//            Go to TRAILER when word_cnt==MAX_WORDS (reason 2'b01).
//             Else when empty & !matching_busy_mux (reason 2'b00).
//             Else when idle_cnt==TIMEOUT-1 and empty (reason 2'b10).
//            Priority on simultaneous conditions: limit > done > timeout.
//   TRAILER: on load_ok, load {4'hC, pkt_id, reason[1:0], 0..., word_cnt[CNT_WIDTH-1:0]}, eof=1.
//            Then pkt_id++ and pkt_count++, both wrapping at 2**16 -> IDLE.
//  tdc_fifo_read_mux: asserted only in DATA and equals pop. Never asserted when empty or when the output is stalled.
//  Latency: popped word appears on out_data the next cycle. Back-to-back pops give 1 word/cycle while out_ready=1.
//  Empty packet: HEADER, then immediate done/timeout -> TRAILER with word_cnt=0.
//   Legal and emitted.
//  matching_busy_mux only affects the close decision. A new packet may start while it is high.
//  Packet overhead: 2 cycles (HEADER, TRAILER). IDLE->HEADER costs 1 cycle.
// STRUCTURE
//  Shared package tdc_readout_pkg:
//   HDR_MARK=4'hA, TRL_MARK=4'hC;
//   close reason codes CLOSE_DONE=2'b00, CLOSE_LIMIT=2'b01, CLOSE_TIMEOUT=2'b10;
//   FSM state encoding.
//  Sub-module tdc_out_reg_slice: 1-deep valid/ready register carrying {sof,eof,data}.
//  The FSM/counters stay in the top.
// TESTING
//  1 Reset mid-DATA (rst_n=0 one cycle after 3 pops) -> out_valid=0 next cycle, pkt_count=0, state IDLE, no trailer.
//  2 5 words queued, matching_busy=0, out_ready=1 -> HDR(pkt_id 0), 5 data in order, TRL reason 00 cnt 5; pkt_count=1.
//  3 MAX_WORDS=4, 10 words queued -> packets of 4,4,2 data words.
//   Reasons 01,01,00. pkt_ids 0,1,2. Exactly 10 pops.
//  4 out_ready toggled 1/0 every cycle during 8-word packet -> no pop while stalled, out_data stable, zero loss/dup.
//  5 TIMEOUT=16, 1 word then empty with matching_busy=1 -> TRL after 16 empty cycles, reason 10, cnt 1.
//  6 Limit and done same cycle (MAX_WORDS-th word is last, busy=0) -> reason 01. pkt_count wraps 0xFFFF->0.

Source files
------------

// File: rtl/tdc_readout_pkg.sv
// Shared constants and FSM encoding for the TDC readout packet framer.
package tdc_readout_pkg;

  localparam logic [3:0] HDR_MARK = 4'hA;
  localparam logic [3:0] TRL_MARK = 4'hC;

  localparam logic [1:0] CLOSE_DONE    = 2'b00;
  localparam logic [1:0] CLOSE_LIMIT   = 2'b01;
  localparam logic [1:0] CLOSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_TRAILER
  } state_t;

endpackage

// File: rtl/tdc_out_reg_slice.sv
// One-deep valid/ready output register carrying {sof, eof, data}; held stable until accepted.
module tdc_out_reg_slice #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [WIDTH-1:0] in_data,
  output logic             load_ok,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_reg;
  logic             sof_reg;
  logic             eof_reg;
  logic [WIDTH-1:0] data_reg;

  assign load_ok = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sof_reg   <= 1'b0;
      eof_reg   <= 1'b0;
      data_reg  <= '0;
    end else if (load_ok) begin
      valid_reg <= in_valid;
      // Payload only moves on a real load so an idle slot keeps the last word.
      if (in_valid) begin
        sof_reg  <= in_sof;
        eof_reg  <= in_eof;
        data_reg <= in_data;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_sof   = sof_reg;
  assign out_eof   = eof_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/tdc_readout_packer.sv
// Frames hit words from the merged FWFT TDC FIFO into HEADER/DATA/TRAILER packets.
module tdc_readout_packer
  import tdc_readout_pkg::*;
#(
  parameter int TDC_DATA_WIDTH = 40,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT        = 1024,
  parameter int CNT_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tdc_fifo_empty_mux,
  input  logic [TDC_DATA_WIDTH-1:0] tdc_fifo_data_mux,
  input  logic                      matching_busy_mux,
  output logic                      tdc_fifo_read_mux,
  output logic [TDC_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic                      out_eof,
  input  logic                      out_ready,
  output logic [15:0]               pkt_count
);

  localparam int W      = TDC_DATA_WIDTH;
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_WORDS);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] word_cnt_reg, word_cnt_next;
  logic [IDLE_W-1:0]    idle_cnt_reg, idle_cnt_next;
  logic [15:0]          pkt_id_reg, pkt_id_next;
  logic [1:0]           reason_reg, reason_next;

  logic         load_ok;
  logic         pop;
  logic         slot_valid;
  logic         slot_sof;
  logic         slot_eof;
  logic [W-1:0] slot_data;
  logic [W-1:0] hdr_word;
  logic [W-1:0] trl_word;

  always_comb begin
    hdr_word = '0;
    hdr_word[W-1 -: 4]  = HDR_MARK;
    hdr_word[W-5 -: 16] = pkt_id_reg;
    trl_word = '0;
    trl_word[W-1 -: 4]  = TRL_MARK;
    trl_word[W-5 -: 16] = pkt_id_reg;
    trl_word[W-21 -: 2] = reason_reg;
    trl_word[CNT_WIDTH-1:0] = word_cnt_reg;
  end

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    pkt_id_next   = pkt_id_reg;
    reason_next   = reason_reg;
    pop           = 1'b0;
    slot_valid    = 1'b0;
    slot_sof      = 1'b0;
    slot_eof      = 1'b0;
    slot_data     = '0;

    case (state_reg)
      ST_IDLE: begin
        if (!tdc_fifo_empty_mux) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        slot_valid = 1'b1;
        slot_sof   = 1'b1;
        slot_data  = hdr_word;
        if (load_ok) begin
          state_next    = ST_DATA;
          word_cnt_next = '0;
          idle_cnt_next = '0;
        end
      end
      ST_DATA: begin
        pop = !tdc_fifo_empty_mux && load_ok && (word_cnt_reg < MAX_CNT);
        if (pop) begin
          slot_valid    = 1'b1;
          slot_data     = tdc_fifo_data_mux;
          word_cnt_next = word_cnt_reg + CNT_WIDTH'(1);
          idle_cnt_next = '0;
        end else if (tdc_fifo_empty_mux && (idle_cnt_reg != '1)) begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
        // Close decisions are exclusive with pop: limit blocks pop, the others need empty.
        if (word_cnt_reg == MAX_CNT) begin
          state_next  = ST_TRAILER;
          reason_next = CLOSE_LIMIT;
        end else if (tdc_fifo_empty_mux && !matching_busy_mux) begin
          state_next  = ST_TRAILER;
          reason_next = CLOSE_DONE;
        end else if (tdc_fifo_empty_mux && (idle_cnt_reg == IDLE_LAST)) begin
          state_next  = ST_TRAILER;
          reason_next = CLOSE_TIMEOUT;
        end
      end
      ST_TRAILER: begin
        slot_valid = 1'b1;
        slot_eof   = 1'b1;
        slot_data  = trl_word;
        if (load_ok) begin
          state_next  = ST_IDLE;
          pkt_id_next = pkt_id_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      pkt_id_reg   <= '0;
      reason_reg   <= CLOSE_DONE;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      pkt_id_reg   <= pkt_id_next;
      reason_reg   <= reason_next;
    end
  end

  // Packet id and completed-packet count advance together, so one register serves both.
  assign pkt_count         = pkt_id_reg;
  assign tdc_fifo_read_mux = pop && rst_n;

  tdc_out_reg_slice #(
    .WIDTH(W)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (slot_valid),
    .in_sof    (slot_sof),
    .in_eof    (slot_eof),
    .in_data   (slot_data),
    .load_ok   (load_ok),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

endmodule
